logic_array_block: RTL and testbench
====================================

// Module: logic_array_block
// PURPOSE
//  Cycle-based model of one MAX7000 Logic Array Block (LAB): consumes PIA signals, selects 36 LAB inputs,
//  evaluates shared expanders and per-macrocell product terms, and registers or passes each macrocell result.
//  Sits directly downstream of programmable_interconnect_array. Its macrocell outputs feed back to the PIA
//  macrocell_output_signals input. Configuration is loaded through a serial shift chain.
// PARAMETERS
//  pia_signal_count       68  width of PIA bus feeding this LAB
//  lab_input_count        36  PIA signals selected into the LAB local array
//  macrocell_count        16  macrocells (and shared expanders) per LAB
//  product_terms_per_cell 5   product terms per macrocell
// PORTS
//  clock                    in   1                      global clock, rising edge
//  reset_n                  in   1                      asynchronous, active-low reset
//  pia_signals              in   pia_signal_count       PIA bus
//  config_shift_enable      in   1                      1 = shift configuration chain this cycle
//  config_data_in           in   1                      serial configuration bit
//  config_data_out          out  1                      last bit of configuration chain
//  macrocell_output_signals out  macrocell_count        macrocell results, to PIA and I/O control
// BEHAVIOUR
//  Config chain: CONFIG_LENGTH bits. Layout and offsets are defined in the package.
//   - lab_input_count selectors of SEL_W = $clog2(pia_signal_count) bits. A selector >= pia_signal_count gives 0.
//   - macrocell_count expander masks, 2*lab_input_count bits each (true/complement literal per input).
//   - Per cell:
//     - product_terms_per_cell masks of 2*lab_input_count+macrocell_count bits.
//     - Flags reg_en, t_mode, invert, pt_clear_en, pt_preset_en.
//  Shift: while config_shift_enable=1, each rising clock does chain <= {chain[L-2:0], config_data_in}.
//   - config_data_out = chain[L-1], combinational from the chain register.
//  Product term = AND of selected literals. An all-zero mask evaluates 0 (erased).
//  Shared expander k = NAND of its selected literals. An all-zero mask gives 1.
//   - Expanders are usable by any cell's PT through mask bits [2*lab_input_count +: macrocell_count].
//  Cell sum = OR of the cell's PTs, excluding PT0 when pt_clear_en=1 and PT1 when pt_preset_en=1.
//  Cell logic = sum XOR invert.
//  Register, updated on the rising clock only when config_shift_enable=0:
//   - D mode (t_mode=0): q <= logic.
//   - T mode: q <= q ^ logic.
//   - PT0=1 with pt_clear_en forces q <= 0.
//   - Else PT1=1 with pt_preset_en forces q <= 1. Clear beats preset when both are active.
//   - PT clear/preset are modelled synchronous (single-clock model).
//  Output: reg_en=1 gives q (latency 1 clock); reg_en=0 gives logic (combinational, latency 0).
//  Hold: during shifting all q hold. Outputs keep following the current chain contents; no gating.
//  reset_n=0, asynchronous:
//   - Chain becomes all zeros, every q becomes 0, so config_data_out=0 and all outputs=0.
//   - Reset mid-shift discards partial configuration.
//  Combinational loops through expanders are impossible: expanders use only LAB inputs.
//   - Macrocell feedback reaches this LAB only via the PIA, outside this block.
// STRUCTURE
//  Package max7000_lab_pkg holds:
//   - SEL_W, LIT_W=2*lab_input_count, PT_W=LIT_W+macrocell_count.
//   - Flag bit indices and per-field offset functions.
//   - CONFIG_LENGTH function of the parameters.
//  Sub-module max7000_macrocell, one instance per cell: PT evaluation, clear/preset steering,
//   D/T register, output mux.
//  Top level holds the config chain, input selectors, expanders and the macrocell generate loop.
// TESTING
//  1. Reset only -> config_data_out=0, macrocell_output_signals=16'h0000, all PIA patterns give 0.
//  2. Shift CONFIG_LENGTH+8 bits with the first 8 = 8'hA5 -> config_data_out emits A5 MSB-first,
//     starting at cycle CONFIG_LENGTH.
//  3. Cell0: input0 selects PIA[4], PT0 = in0 true, combinational.
//     -> pia[4]=1 gives out[0]=1 the same cycle; invert=1 gives 0.
//  4. Cell3: registered D, PT0 = in0 AND NOT in1.
//     -> out[3] rises one clock after pia {in1,in0} = 2'b01, and holds while config_shift_enable=1.
//  5. Cell5: T mode, PT0=1 constantly -> out[5] toggles 0,1,0,1 on successive clocks.
//     With pt_clear_en=1 it stays 0.
//  6. Cell7: pt_clear_en and pt_preset_en with PT0=PT1=1 -> q=0.
//     reset_n pulsed low between clocks -> out=0 immediately and the chain reads all zero.

Source files
------------

// File: rtl/max7000_lab_pkg.sv
// Shared sizes, configuration-chain layout and decoded cell flags for one MAX7000 LAB.
package max7000_lab_pkg;

    localparam int PIA_N    = 68;
    localparam int LAB_IN_N = 36;
    localparam int MC_N     = 16;
    localparam int PT_N     = 5;

    localparam int SEL_W  = $clog2(PIA_N);
    localparam int LIT_W  = 2 * LAB_IN_N;
    localparam int PT_W   = LIT_W + MC_N;
    localparam int FLAG_N = 5;
    localparam int CELL_W = PT_N * PT_W + FLAG_N;

    localparam int FLAG_REG_EN = 0;
    localparam int FLAG_T_MODE = 1;
    localparam int FLAG_INVERT = 2;
    localparam int FLAG_CLR_EN = 3;
    localparam int FLAG_PRE_EN = 4;

    // Packed so that bit FLAG_x of the flag field lands on the matching member.
    typedef struct packed {
        logic pt_preset_en;
        logic pt_clear_en;
        logic invert;
        logic t_mode;
        logic reg_en;
    } cell_flags_t;

    function automatic int sel_off(input int i);
        return i * SEL_W;
    endfunction

    function automatic int exp_off(input int k);
        return LAB_IN_N * SEL_W + k * LIT_W;
    endfunction

    function automatic int cell_off(input int c);
        return exp_off(MC_N) + c * CELL_W;
    endfunction

    function automatic int pt_off(input int c, input int p);
        return cell_off(c) + p * PT_W;
    endfunction

    function automatic int flag_off(input int c);
        return cell_off(c) + PT_N * PT_W;
    endfunction

    function automatic int config_length();
        return cell_off(MC_N);
    endfunction

    localparam int CONFIG_LENGTH = config_length();

endpackage

// File: rtl/logic_array_block_if.sv
// PIA-side bus of one LAB: PIA signals in, configuration chain, macrocell results out.
interface logic_array_block_if;

    logic [max7000_lab_pkg::PIA_N-1:0] pia_signals;
    logic                              config_shift_enable;
    logic                              config_data_in;
    logic                              config_data_out;
    logic [max7000_lab_pkg::MC_N-1:0]  macrocell_output_signals;

    modport master (
        output pia_signals,
        output config_shift_enable,
        output config_data_in,
        input  config_data_out,
        input  macrocell_output_signals
    );

    modport slave (
        input  pia_signals,
        input  config_shift_enable,
        input  config_data_in,
        output config_data_out,
        output macrocell_output_signals
    );

endinterface

// File: rtl/max7000_macrocell.sv
// One macrocell: product terms over LAB literals and expanders, clear/preset steering,
// D/T register held while the configuration chain shifts, and registered/combinational output mux.
module max7000_macrocell
    import max7000_lab_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_hold,
    input  logic [PT_W-1:0]   i_pt_src,
    input  logic [CELL_W-1:0] i_cell_cfg,
    output logic              o_out
);

    cell_flags_t     w_flags;
    logic [PT_N-1:0] w_pt;
    logic [PT_N-1:0] w_pt_use;
    logic            w_sum;
    logic            w_logic;
    logic            w_clr;
    logic            w_pre;
    logic            w_q_next;
    logic            r_q;

    assign w_flags = cell_flags_t'(i_cell_cfg[PT_N*PT_W +: FLAG_N]);

    // An erased (all-zero) mask must read 0, not the empty-AND value 1.
    for (genvar p = 0; p < PT_N; p++) begin : g_pt
        logic [PT_W-1:0] w_mask;
        assign w_mask  = i_cell_cfg[p*PT_W +: PT_W];
        assign w_pt[p] = (|w_mask) & (&(~w_mask | i_pt_src));
    end

    always_comb begin
        w_pt_use    = '1;
        w_pt_use[0] = ~w_flags.pt_clear_en;
        w_pt_use[1] = ~w_flags.pt_preset_en;
    end

    assign w_sum   = |(w_pt & w_pt_use);
    assign w_logic = w_sum ^ w_flags.invert;
    assign w_clr   = w_flags.pt_clear_en  & w_pt[0];
    assign w_pre   = w_flags.pt_preset_en & w_pt[1];

    always_comb begin
        w_q_next = r_q;
        if (w_clr) begin
            w_q_next = 1'b0;
        end else if (w_pre) begin
            w_q_next = 1'b1;
        end else if (w_flags.t_mode) begin
            w_q_next = r_q ^ w_logic;
        end else begin
            w_q_next = w_logic;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q <= 1'b0;
        end else if (!i_hold) begin
            r_q <= w_q_next;
        end
    end

    assign o_out = w_flags.reg_en ? r_q : w_logic;

endmodule

// File: rtl/logic_array_block.sv
// MAX7000 LAB: serial configuration chain, PIA input selectors, shared expanders
// and the macrocell array. Macrocell feedback returns only through the external PIA.
module logic_array_block
    import max7000_lab_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    logic_array_block_if.slave lab
);

    logic [CONFIG_LENGTH-1:0] r_chain;
    logic [LAB_IN_N-1:0]      w_lab_in;
    logic [LIT_W-1:0]         w_lit;
    logic [MC_N-1:0]          w_exp;
    logic [PT_W-1:0]          w_pt_src;
    logic [MC_N-1:0]          w_mc_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else if (lab.config_shift_enable) begin
            r_chain <= {r_chain[CONFIG_LENGTH-2:0], lab.config_data_in};
        end
    end

    assign lab.config_data_out = r_chain[CONFIG_LENGTH-1];

    // Selector codes beyond the PIA width select a constant 0.
    for (genvar i = 0; i < LAB_IN_N; i++) begin : g_sel
        logic [SEL_W-1:0] w_sel;
        assign w_sel         = r_chain[sel_off(i) +: SEL_W];
        assign w_lab_in[i]   = (w_sel < SEL_W'(PIA_N)) ? lab.pia_signals[w_sel] : 1'b0;
        assign w_lit[2*i]    = w_lab_in[i];
        assign w_lit[2*i+1]  = ~w_lab_in[i];
    end

    for (genvar k = 0; k < MC_N; k++) begin : g_exp
        logic [LIT_W-1:0] w_mask;
        assign w_mask   = r_chain[exp_off(k) +: LIT_W];
        assign w_exp[k] = (w_mask == '0) ? 1'b1 : ~(&(~w_mask | w_lit));
    end

    assign w_pt_src = {w_exp, w_lit};

    for (genvar c = 0; c < MC_N; c++) begin : g_mc
        max7000_macrocell u_mc (
            .i_clock    (clock),
            .i_reset_n  (reset_n),
            .i_hold     (lab.config_shift_enable),
            .i_pt_src   (w_pt_src),
            .i_cell_cfg (r_chain[cell_off(c) +: CELL_W]),
            .o_out      (w_mc_out[c])
        );
    end

    assign lab.macrocell_output_signals = w_mc_out;

endmodule

// File: tb/tb_logic_array_block.sv
// Directed bench for logic_array_block: reset state, chain streaming, combinational,
// registered D/T, clear/preset priority, expander NAND and out-of-range selector.
module tb_logic_array_block;
    import max7000_lab_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [CONFIG_LENGTH-1:0] cfg;
    logic [7:0]               a5;
    logic [7:0]               got_byte;
    int                       ones;

    logic_array_block_if lab_bus ();

    logic_array_block dut (
        .clock   (clock),
        .reset_n (reset_n),
        .lab     (lab_bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_sel(input int i, input int v);
        for (int b = 0; b < SEL_W; b++) cfg[sel_off(i) + b] = v[b];
    endtask

    task automatic cfg_bit(input int off);
        cfg[off] = 1'b1;
    endtask

    task automatic load_cfg();
        for (int i = CONFIG_LENGTH - 1; i >= 0; i--) begin
            lab_bus.config_shift_enable = 1'b1;
            lab_bus.config_data_in      = cfg[i];
            tick();
        end
        lab_bus.config_shift_enable = 1'b0;
        lab_bus.config_data_in      = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n                     = 1'b0;
        lab_bus.pia_signals         = '0;
        lab_bus.config_shift_enable = 1'b0;
        lab_bus.config_data_in      = 1'b0;

        // Reset only
        repeat (2) tick();
        check_eq("rst_dout", 32'(lab_bus.config_data_out), 32'h0);
        check_eq("rst_out", 32'(lab_bus.macrocell_output_signals), 32'h0);
        reset_n = 1'b1;
        lab_bus.pia_signals = '1;
        tick();
        check_eq("rst_pia_ones", 32'(lab_bus.macrocell_output_signals), 32'h0);
        lab_bus.pia_signals = 68'h5_5555_5555_5555_5555;
        tick();
        check_eq("rst_pia_5s", 32'(lab_bus.macrocell_output_signals), 32'h0);
        lab_bus.pia_signals = {4'($urandom), $urandom, $urandom};
        tick();
        check_eq("rst_pia_rand", 32'(lab_bus.macrocell_output_signals), 32'h0);
        lab_bus.pia_signals = '0;

        // Stream A5 through the whole chain
        a5 = 8'hA5;
        got_byte = '0;
        for (int n = 1; n <= CONFIG_LENGTH + 8; n++) begin
            lab_bus.config_shift_enable = 1'b1;
            lab_bus.config_data_in      = 1'b0;
            if (n <= 8) lab_bus.config_data_in = a5[8-n];
            tick();
            if (n == CONFIG_LENGTH - 1)
                check_eq("dout_before_stream", 32'(lab_bus.config_data_out), 32'h0);
            if (n >= CONFIG_LENGTH && n < CONFIG_LENGTH + 8)
                got_byte = {got_byte[6:0], lab_bus.config_data_out};
        end
        lab_bus.config_shift_enable = 1'b0;
        check_eq("dout_a5_stream", 32'(got_byte), 32'hA5);

        // Configuration A
        pulse_reset();
        cfg = '0;
        cfg_sel(0, 4);
        cfg_sel(1, 9);
        cfg_sel(2, 100);
        cfg_bit(exp_off(1) + 0);
        cfg_bit(exp_off(1) + 2);
        cfg_bit(pt_off(0, 0) + 0);
        cfg_bit(pt_off(3, 0) + 0);
        cfg_bit(pt_off(3, 0) + 3);
        // Cell3 PT4 = in1 & exp15; its top mask bit becomes reg_en after a one-bit shift,
        // so the output still shows q during the hold check.
        cfg_bit(pt_off(3, 4) + 2);
        cfg_bit(pt_off(3, 4) + PT_W - 1);
        cfg_bit(flag_off(3) + FLAG_REG_EN);
        cfg_bit(pt_off(5, 0) + LIT_W);
        cfg_bit(flag_off(5) + FLAG_REG_EN);
        cfg_bit(flag_off(5) + FLAG_T_MODE);
        cfg_bit(pt_off(7, 0) + LIT_W);
        cfg_bit(pt_off(7, 1) + LIT_W);
        cfg_bit(flag_off(7) + FLAG_REG_EN);
        cfg_bit(flag_off(7) + FLAG_CLR_EN);
        cfg_bit(flag_off(7) + FLAG_PRE_EN);
        cfg_bit(pt_off(8, 1) + LIT_W);
        cfg_bit(flag_off(8) + FLAG_REG_EN);
        cfg_bit(flag_off(8) + FLAG_PRE_EN);
        cfg_bit(pt_off(9, 0) + LIT_W + 1);
        cfg_bit(pt_off(10, 0) + 5);
        lab_bus.pia_signals = '0;
        load_cfg();

        check_eq("a_loaded", 32'(lab_bus.macrocell_output_signals), 32'h0600);
        lab_bus.pia_signals[4] = 1'b1;
        #1;
        check_eq("a_comb_cell0", 32'(lab_bus.macrocell_output_signals), 32'h0601);
        tick();
        check_eq("a_clk1", 32'(lab_bus.macrocell_output_signals), 32'h0729);
        lab_bus.pia_signals = '1;
        #1;
        check_eq("a_pia_ones", 32'(lab_bus.macrocell_output_signals), 32'h0529);
        tick();
        check_eq("a_clk2", 32'(lab_bus.macrocell_output_signals), 32'h0509);
        tick();
        check_eq("a_clk3", 32'(lab_bus.macrocell_output_signals), 32'h0529);
        lab_bus.pia_signals = '0;
        #1;
        check_eq("a_pre_hold", 32'(lab_bus.macrocell_output_signals), 32'h0728);
        lab_bus.config_shift_enable = 1'b1;
        lab_bus.config_data_in      = 1'b0;
        tick();
        lab_bus.config_shift_enable = 1'b0;
        check_eq("a_hold_cell3", 32'(lab_bus.macrocell_output_signals[3]), 32'h1);

        // Configuration B: inverted cell0, T cell5 pinned by clear
        pulse_reset();
        cfg = '0;
        cfg_sel(0, 4);
        cfg_bit(pt_off(0, 0) + 0);
        cfg_bit(flag_off(0) + FLAG_INVERT);
        cfg_bit(pt_off(5, 0) + LIT_W);
        cfg_bit(flag_off(5) + FLAG_REG_EN);
        cfg_bit(flag_off(5) + FLAG_T_MODE);
        cfg_bit(flag_off(5) + FLAG_CLR_EN);
        cfg_bit(pt_off(7, 0) + LIT_W);
        cfg_bit(pt_off(7, 1) + LIT_W);
        cfg_bit(flag_off(7) + FLAG_REG_EN);
        cfg_bit(flag_off(7) + FLAG_CLR_EN);
        cfg_bit(flag_off(7) + FLAG_PRE_EN);
        cfg_bit(pt_off(8, 1) + LIT_W);
        cfg_bit(flag_off(8) + FLAG_REG_EN);
        cfg_bit(flag_off(8) + FLAG_PRE_EN);
        lab_bus.pia_signals = '0;
        load_cfg();

        check_eq("b_inv_low", 32'(lab_bus.macrocell_output_signals), 32'h0001);
        lab_bus.pia_signals[4] = 1'b1;
        #1;
        check_eq("b_inv_high", 32'(lab_bus.macrocell_output_signals), 32'h0000);
        tick();
        check_eq("b_clk1", 32'(lab_bus.macrocell_output_signals), 32'h0100);
        tick();
        check_eq("b_clk2", 32'(lab_bus.macrocell_output_signals), 32'h0100);

        // Asynchronous reset between clocks
        reset_n = 1'b0;
        #1;
        check_eq("rst_async_out", 32'(lab_bus.macrocell_output_signals), 32'h0);
        check_eq("rst_async_dout", 32'(lab_bus.config_data_out), 32'h0);
        #1;
        reset_n = 1'b1;
        ones = 0;
        for (int n = 0; n < CONFIG_LENGTH; n++) begin
            if (lab_bus.config_data_out) ones++;
            lab_bus.config_shift_enable = 1'b1;
            lab_bus.config_data_in      = 1'b1;
            tick();
        end
        lab_bus.config_shift_enable = 1'b0;
        check_eq("rst_chain_ones", 32'(ones), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
